// File: rtl/pipe_ifid_pkg.sv
// Shared IF/ID definitions: fetch FSM encoding and default reset/bubble values.
package pipe_ifid_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        PROG = 2'd2
    } state_t;

    localparam logic [31:0] PKG_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PKG_NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/pipe_ifid_dffe32.sv
// 32-bit register with load enable and synchronous reset to a fixed value.
module dffe32 #(
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipe_ifid.sv
// IF/ID pipeline boundary: PC register, decode latch, stall/flush/program sequencing.
//   state | meaning
//   RUN   | fetching and advancing normally
//   HOLD  | load-use interlock, PC and D register frozen
//   PROG  | instruction memory being programmed, fetch disabled, bubbles issued
module pipe_ifid
    import pipe_ifid_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PKG_RESET_PC,
    parameter logic [31:0] NOP_INST = PKG_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_i,
    input  logic [31:0] pc8_i,
    input  logic [31:0] inst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        prog_i,
    output logic [31:0] pc_o,
    output logic        ram_ena_o,
    output logic [31:0] d_inst_o,
    output logic [31:0] d_pc_o,
    output logic [31:0] d_pc8_o,
    output logic        d_valid_o,
    output logic [15:0] stall_cnt_o
);

    state_t      state;
    logic        advance;
    logic        bubble;
    logic        pc_en;
    logic        inst_en;
    logic [31:0] inst_d;

    // Bubbles only rewrite the instruction; the PC fields of a dead slot keep their last value.
    always_comb begin
        bubble  = prog_i | flush_i;
        advance = ~prog_i & ~flush_i & ~stall_i;
        pc_en   = ~prog_i & (flush_i | ~stall_i);
        inst_en = bubble | advance;
        inst_d  = bubble ? NOP_INST : inst_i;
    end

    dffe32 #(.RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(pc_en), .d(npc_i), .q(pc_o)
    );

    dffe32 #(.RST_VAL(NOP_INST)) u_d_inst (
        .clk(clk), .rst(rst), .en(inst_en), .d(inst_d), .q(d_inst_o)
    );

    dffe32 #(.RST_VAL(32'h0000_0000)) u_d_pc (
        .clk(clk), .rst(rst), .en(advance), .d(pc_o), .q(d_pc_o)
    );

    dffe32 #(.RST_VAL(32'h0000_0000)) u_d_pc8 (
        .clk(clk), .rst(rst), .en(advance), .d(pc8_i), .q(d_pc8_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            ram_ena_o   <= 1'b1;
            d_valid_o   <= 1'b0;
            stall_cnt_o <= 16'h0000;
        end else if (prog_i) begin
            state     <= PROG;
            ram_ena_o <= 1'b0;
            d_valid_o <= 1'b0;
            if (stall_cnt_o != 16'hFFFF)
                stall_cnt_o <= stall_cnt_o + 16'd1;
        end else if (flush_i) begin
            state     <= RUN;
            ram_ena_o <= 1'b1;
            d_valid_o <= 1'b0;
        end else if (stall_i) begin
            state     <= HOLD;
            ram_ena_o <= 1'b1;
            if (stall_cnt_o != 16'hFFFF)
                stall_cnt_o <= stall_cnt_o + 16'd1;
        end else begin
            state     <= RUN;
            ram_ena_o <= 1'b1;
            d_valid_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ifid.sv
// Randomized self-checking bench for pipe_ifid against a rule-level reference model.
module tb_pipe_ifid;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] T_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, prog_i;
    logic [31:0] npc_i, pc8_i, inst_i;
    logic [31:0] pc_o, d_inst_o, d_pc_o, d_pc8_o;
    logic        ram_ena_o, d_valid_o;
    logic [15:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;

    // reference model of the visible state
    logic [31:0] m_pc, m_inst, m_dpc, m_dpc8;
    logic        m_valid, m_ram;
    logic [15:0] m_cnt;
    logic [1:0]  m_state;

    always #5 clk = ~clk;

    pipe_ifid #(.RESET_PC(T_RESET_PC), .NOP_INST(T_NOP)) dut (
        .clk(clk), .rst(rst), .npc_i(npc_i), .pc8_i(pc8_i), .inst_i(inst_i),
        .stall_i(stall_i), .flush_i(flush_i), .prog_i(prog_i),
        .pc_o(pc_o), .ram_ena_o(ram_ena_o), .d_inst_o(d_inst_o), .d_pc_o(d_pc_o),
        .d_pc8_o(d_pc8_o), .d_valid_o(d_valid_o), .stall_cnt_o(stall_cnt_o)
    );

    wire [147:0] obs = {pc_o, d_inst_o, d_pc_o, d_pc8_o, d_valid_o, ram_ena_o,
                        stall_cnt_o, dut.state};

    function automatic logic [147:0] exp_vec();
        return {m_pc, m_inst, m_dpc, m_dpc8, m_valid, m_ram, m_cnt, m_state};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Drive one cycle of inputs, advance the model by the block's rules, sample #1 after the edge.
    task automatic step(input logic r, input logic st, input logic fl, input logic pg,
                        input logic [31:0] npc, input logic [31:0] p8, input logic [31:0] ins);
        rst = r; stall_i = st; flush_i = fl; prog_i = pg;
        npc_i = npc; pc8_i = p8; inst_i = ins;
        if (r) begin
            m_pc = T_RESET_PC; m_inst = T_NOP; m_dpc = 0; m_dpc8 = 0;
            m_valid = 0; m_cnt = 0; m_ram = 1; m_state = 2'd0;
        end else if (pg) begin
            m_inst = T_NOP; m_valid = 0; m_ram = 0; m_cnt = sat_inc(m_cnt); m_state = 2'd2;
        end else if (fl) begin
            m_pc = npc; m_inst = T_NOP; m_valid = 0; m_ram = 1; m_state = 2'd0;
        end else if (st) begin
            m_ram = 1; m_cnt = sat_inc(m_cnt); m_state = 2'd1;
        end else begin
            m_dpc = m_pc; m_dpc8 = p8; m_inst = ins; m_pc = npc;
            m_valid = 1; m_ram = 1; m_state = 2'd0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, $urandom, $urandom, $urandom);
        total++;
        if (obs !== exp_vec() || pc_o !== 32'h0 || d_inst_o !== T_NOP || ram_ena_o !== 1'b1) begin
            bad++;
            $display("FAIL reset: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_advance();
        step(0, 0, 0, 0, 32'h4, 32'h8, 32'h2008_0005);
        total++;
        if (pc_o !== 32'h4 || d_inst_o !== 32'h2008_0005 || d_pc_o !== 32'h0 || d_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL advance_first: pc=%h inst=%h dpc=%h v=%b want 4 20080005 0 1",
                     pc_o, d_inst_o, d_pc_o, d_valid_o);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, $urandom, $urandom, $urandom);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL advance_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] hold_pc, hold_inst;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 32'h40, 32'h48, 32'hAAAA_5555);
        hold_pc = pc_o; hold_inst = d_inst_o;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, $urandom, $urandom, $urandom);
            total++;
            if (obs !== exp_vec() || pc_o !== hold_pc || d_inst_o !== hold_inst) begin
                bad++;
                $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        total++;
        if (stall_cnt_o !== 16'd3) begin
            bad++;
            $display("FAIL stall_count: got %0d want 3", stall_cnt_o);
        end
        step(0, 0, 0, 0, 32'h44, 32'h4C, 32'h1234_5678);
        total++;
        if (obs !== exp_vec() || pc_o !== 32'h44 || d_pc_o !== 32'h40) begin
            bad++;
            $display("FAIL stall_release: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_flush();
        step(0, 1, 1, 0, 32'h100, $urandom, $urandom);
        total++;
        if (obs !== exp_vec() || pc_o !== 32'h100 || d_valid_o !== 1'b0 || d_inst_o !== T_NOP) begin
            bad++;
            $display("FAIL flush_over_stall: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_prog();
        logic [31:0] frz;
        frz = pc_o;
        for (int i = 0; i < 5; i++) begin
            step(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom, $urandom, $urandom);
            total++;
            if (obs !== exp_vec() || ram_ena_o !== 1'b0 || pc_o !== frz || d_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL prog_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        step(0, 0, 0, 0, $urandom, $urandom, $urandom);
        total++;
        if (obs !== exp_vec() || ram_ena_o !== 1'b1) begin
            bad++;
            $display("FAIL prog_exit: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom, $urandom, $urandom);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_saturate();
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65534; i++)
            step(0, 1, 0, 0, $urandom, $urandom, $urandom);
        total++;
        if (stall_cnt_o !== 16'hFFFE) begin
            bad++;
            $display("FAIL sat_preload: got %h want fffe", stall_cnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, i == 2, $urandom, $urandom, $urandom);
            total++;
            if (obs !== exp_vec() || stall_cnt_o !== 16'hFFFF) begin
                bad++;
                $display("FAIL sat_hold_%0d: cnt=%h got %h want %h", i, stall_cnt_o, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 0, 32'h200, 32'h208, 32'hDEAD_BEEF);
        step(0, 1, 0, 0, $urandom, $urandom, $urandom);
        step(0, 1, 0, 0, $urandom, $urandom, $urandom);
        step(1, 1, 0, 0, $urandom, $urandom, $urandom);
        total++;
        if (obs !== exp_vec() || dut.state !== 2'd0 || stall_cnt_o !== 16'd0) begin
            bad++;
            $display("FAIL reset_in_hold: got %h want %h", obs, exp_vec());
        end
        step(0, 0, 0, 0, 32'h300, 32'h308, 32'hCAFE_F00D);
        step(0, 0, 0, 1, $urandom, $urandom, $urandom);
        step(0, 0, 0, 1, $urandom, $urandom, $urandom);
        step(1, 0, 0, 1, $urandom, $urandom, $urandom);
        total++;
        if (obs !== exp_vec() || dut.state !== 2'd0 || ram_ena_o !== 1'b1 || d_pc_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_in_prog: got %h want %h", obs, exp_vec());
        end
    endtask

    initial begin
        rst = 1; stall_i = 0; flush_i = 0; prog_i = 0;
        npc_i = 0; pc8_i = 0; inst_i = 0;
        test_reset();
        test_advance();
        test_stall();
        test_flush();
        test_prog();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ifid.md
PIPE_IFID -- requirements
Module: pipe_ifid

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL provide parameter NOP_INST, default 32'h0000_0000, the instruction word injected as a bubble.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port npc_i  input  32  next PC selected by the fetch stage.
REQ-006 SHALL have port pc8_i  input  32  PC+8 of the instruction currently being fetched.
REQ-007 SHALL have port inst_i  input  32  instruction memory output for the address on pc_o, valid in the same cycle.
REQ-008 SHALL have port stall_i  input  1  load-use interlock from decode: hold PC and the D register.
REQ-009 SHALL have port flush_i  input  1  kill the instruction now in fetch.
REQ-010 SHALL have port prog_i  input  1  instruction-memory programming request.
REQ-011 SHALL have port pc_o  output  32  current PC, driven to the fetch stage.
REQ-012 SHALL have port ram_ena_o  output  1  instruction memory enable.
REQ-013 SHALL have port d_inst_o, d_pc_o, d_pc8_o  output  32 each  the decode-stage instruction, its PC and its PC+8.
REQ-014 SHALL have port d_valid_o  output  1  the D register holds a real instruction.
REQ-015 SHALL have port stall_cnt_o  output  16  saturating count of stalled cycles.

Function
REQ-016 SHALL implement a three-state FSM: RUN, HOLD, PROG.
REQ-017 SHALL apply per-cycle priority rst > prog_i > flush_i > stall_i > normal advance.
REQ-018 RUN, normal advance: pc_o <= npc_i; D register <= {inst_i, pc_o, pc8_i}; d_valid_o <= 1.
REQ-019 stall_i=1 (no prog, no flush): pc_o and the D register SHALL hold their values, state SHALL go to HOLD, and stall_cnt_o SHALL increment.
REQ-020 HOLD SHALL persist while stall_i=1 and return to RUN in the first cycle stall_i=0; that cycle SHALL perform a normal advance.
REQ-021 flush_i=1 SHALL load pc_o <= npc_i, d_inst_o <= NOP_INST, d_valid_o <= 0, and go to RUN, overriding any simultaneous stall_i.
REQ-022 prog_i=1 from any state SHALL go to PROG.
REQ-023 In PROG: pc_o SHALL be frozen, ram_ena_o <= 0, the D register SHALL be loaded with a bubble every cycle, and stall_cnt_o SHALL increment.
REQ-024 PROG SHALL exit to RUN in the first cycle prog_i=0; ram_ena_o SHALL return to 1 in that same cycle.
REQ-025 ram_ena_o SHALL be 1 in RUN and HOLD.
REQ-026 stall_cnt_o SHALL saturate at 16'hFFFF and never wrap.
REQ-027 pc_o SHALL wrap modulo 2^32 as supplied by npc_i; the block SHALL perform no arithmetic on PC.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL set pc_o=RESET_PC, d_inst_o=NOP_INST, d_pc_o=0, d_pc8_o=0, d_valid_o=0, stall_cnt_o=0, ram_ena_o=1, state=RUN.
REQ-030 Reset SHALL take effect from any state, including mid-HOLD and mid-PROG, with no residue of the prior state.

Structure
REQ-031 The state encoding (RUN=2'd0, HOLD=2'd1, PROG=2'd2), RESET_PC and NOP_INST SHALL live in the shared cpu package/header.
REQ-032 One sub-module SHALL be instantiated: dffe32, a 32-bit enabled register with synchronous reset, used for pc_o and for each D field.

Verification
REQ-033 Reset, then advance with npc_i=0x4, inst_i=0x20080005 -> next cycle pc_o=0x4, d_inst_o=0x20080005, d_pc_o=0x0, d_valid_o=1.
REQ-034 stall_i high for 3 cycles -> pc_o and the D register unchanged for those 3 cycles, stall_cnt_o=3, and advance on the 4th cycle.
REQ-035 stall_i=1 and flush_i=1 together, npc_i=0x100 -> pc_o=0x100, d_valid_o=0, d_inst_o=NOP_INST.
REQ-036 prog_i high 5 cycles -> ram_ena_o=0, pc_o frozen, d_valid_o=0 throughout; ram_ena_o=1 on the cycle after prog_i falls.
REQ-037 Force stall_cnt_o to 0xFFFE, then stall 3 cycles -> stall_cnt_o=0xFFFF, held.
REQ-038 Assert rst during HOLD and during PROG -> all outputs equal the REQ-029 values the next cycle, state=RUN.
